// File: rtl/cc_pkg.sv
// Shared widths and FSM state type for the line assembler and the downstream serializer.
package cc_pkg;
  localparam int BEAT_W       = 64;
  localparam int LINE_W       = 512;
  localparam int BEATS        = 8;
  localparam int OFS_W        = 3;
  localparam int FIFO_ENTRY_W = 518;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PUSH = 2'd2
  } cc_state_e;
endpackage

// File: rtl/cc_line_assembler.sv
// Collects eight 64-bit memory beats into one 512-bit cache line and pushes
// {offset, 3'b000, line} into the downstream line FIFO.
module cc_line_assembler
  import cc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [OFS_W-1:0]        req_offset_i,
  input  logic [BEAT_W-1:0]       mem_rdata_i,
  input  logic                    mem_rlast_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_rready_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_wren_o,
  output logic [FIFO_ENTRY_W-1:0] fifo_wdata_o,
  output logic                    err_o
);

  cc_state_e         r_state, w_next;
  logic [2:0]        r_count;
  logic [OFS_W-1:0]  r_offset;
  logic [LINE_W-1:0] r_line;
  logic              r_err;

  logic w_beat, w_last_beat;
  assign w_beat      = (r_state == ST_FILL) && mem_rvalid_i;
  assign w_last_beat = (r_count == 3'd7);

  always_comb begin
    w_next       = r_state;
    req_ready_o  = 1'b0;
    mem_rready_o = 1'b0;
    fifo_wren_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_next = ST_FILL;
      end
      ST_FILL: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i && w_last_beat) w_next = ST_PUSH;
      end
      ST_PUSH: begin
        fifo_wren_o = !fifo_full_i;
        if (!fifo_full_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_offset <= '0;
      r_line   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req_valid_i) begin
        r_offset <= req_offset_i;
        r_count  <= '0;
      end
      if (w_beat) begin
        // Beat 0 is the most significant word of the line.
        r_line[LINE_W-1-BEAT_W*r_count -: BEAT_W] <= mem_rdata_i;
        r_count <= r_count + 3'd1;
        if (mem_rlast_i != w_last_beat) r_err <= 1'b1;
      end
    end
  end

  assign fifo_wdata_o = {r_offset, 3'b000, r_line};
  assign err_o        = r_err;

endmodule

// File: tb/tb_cc_line_assembler.sv
// Randomized self-checking bench for cc_line_assembler against a line-level model.
module tb_cc_line_assembler;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [2:0]   req_offset_i;
  logic [63:0]  mem_rdata_i;
  logic         mem_rlast_i;
  logic         mem_rvalid_i;
  logic         mem_rready_o;
  logic         fifo_full_i;
  logic         fifo_wren_o;
  logic [517:0] fifo_wdata_o;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;

  int           wr_cnt = 0;
  logic [517:0] wr_data = '0;
  logic [63:0]  words [8];
  logic         err_exp = 1'b0;

  always #5 clk = ~clk;

  cc_line_assembler dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_offset_i(req_offset_i),
    .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rready_o(mem_rready_o), .fifo_full_i(fifo_full_i), .fifo_wren_o(fifo_wren_o),
    .fifo_wdata_o(fifo_wdata_o), .err_o(err_o)
  );

  // Records every FIFO write seen on a clock edge.
  always @(posedge clk) begin
    if (fifo_wren_o) begin
      wr_cnt  <= wr_cnt + 1;
      wr_data <= fifo_wdata_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: line is the eight words concatenated, first beat most significant.
  function automatic logic [517:0] exp_entry(input logic [2:0] ofs);
    logic [511:0] line;
    line = '0;
    for (int k = 0; k < 8; k++) line = (line << 64) | {448'd0, words[k]};
    return {ofs, 3'b000, line};
  endfunction

  task automatic rand_words();
    for (int k = 0; k < 8; k++) words[k] = {$urandom, $urandom};
  endtask

  task automatic do_req(input logic [2:0] ofs);
    int guard;
    guard = 0;
    while (!req_ready_o && guard < 20) begin tick(); guard++; end
    n_tests++;
    if (!req_ready_o) begin
      n_fail++;
      $display("FAIL req_ready_timeout actual=%0b required=1", req_ready_o);
    end
    req_valid_i = 1'b1; req_offset_i = ofs;
    tick();
    req_valid_i = 1'b0; req_offset_i = $urandom;
  endtask

  // Drives beats k0..k1; rlast marked on beat rlast_beat; gap_pct chance of idle cycles.
  task automatic feed(input int k0, input int k1, input int rlast_beat, input int gap_pct);
    for (int k = k0; k <= k1; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        mem_rvalid_i = 1'b0; mem_rdata_i = {$urandom, $urandom}; mem_rlast_i = $urandom;
        tick();
      end
      mem_rvalid_i = 1'b1; mem_rdata_i = words[k]; mem_rlast_i = (k == rlast_beat);
      if ((k == rlast_beat) != (k == 7)) err_exp = 1'b1;
      tick();
    end
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_tests++;
    if ({req_ready_o, mem_rready_o, fifo_wren_o, err_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl actual=%b required=1000", {req_ready_o, mem_rready_o, fifo_wren_o, err_o});
    end
    n_tests++;
    if (fifo_wdata_o !== '0) begin
      n_fail++; $display("FAIL reset_wdata actual=%h required=0", fifo_wdata_o);
    end
  endtask

  task automatic test_basic();
    int w0;
    for (int k = 0; k < 8; k++) words[k] = 64'h1111_1111_1111_1111 * k;
    w0 = wr_cnt;
    do_req(3'd3);
    feed(0, 7, 7, 0);
    n_tests++;
    if (fifo_wren_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_wren_latency actual=%b required=1", fifo_wren_o);
    end
    n_tests++;
    if (fifo_wdata_o !== exp_entry(3'd3) || fifo_wdata_o[63:0] !== 64'h7777_7777_7777_7777) begin
      n_fail++; $display("FAIL basic_wdata actual=%h required=%h", fifo_wdata_o, exp_entry(3'd3));
    end
    n_tests++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL basic_err actual=%b required=0", err_o); end
    tick();
    n_tests++;
    if (wr_cnt !== w0 + 1 || req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_one_write writes=%0d required=%0d ready=%b", wr_cnt - w0, 1, req_ready_o);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    logic [2:0] ofs;
    ofs = $urandom; rand_words(); w0 = wr_cnt;
    do_req(ofs);
    fifo_full_i = 1'b1;
    feed(0, 7, 7, 0);
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (fifo_wren_o !== 1'b0 || fifo_wdata_o !== exp_entry(ofs) || req_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d wren=%b required=0 data=%h required=%h", c, fifo_wren_o, fifo_wdata_o, exp_entry(ofs));
      end
      tick();
    end
    fifo_full_i = 1'b0; #1;
    n_tests++;
    if (fifo_wren_o !== 1'b1) begin n_fail++; $display("FAIL bp_release actual=%b required=1", fifo_wren_o); end
    tick();
    n_tests++;
    if (wr_cnt !== w0 + 1 || wr_data !== exp_entry(ofs)) begin
      n_fail++; $display("FAIL bp_write writes=%0d required=1 data=%h required=%h", wr_cnt - w0, wr_data, exp_entry(ofs));
    end
  endtask

  task automatic test_gaps();
    int w0;
    logic [2:0] ofs;
    ofs = $urandom; rand_words(); w0 = wr_cnt;
    do_req(ofs);
    // Alternating valid pattern first, then random gaps.
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = words[k]; mem_rlast_i = 1'b0; tick();
      mem_rvalid_i = 1'b0; mem_rdata_i = ~words[k]; tick();
    end
    feed(4, 7, 7, 50);
    tick();
    n_tests++;
    if (wr_cnt !== w0 + 1 || wr_data !== exp_entry(ofs)) begin
      n_fail++; $display("FAIL gaps_line writes=%0d required=1 data=%h required=%h", wr_cnt - w0, wr_data, exp_entry(ofs));
    end
  endtask

  task automatic test_rlast_err();
    int w0;
    rand_words(); w0 = wr_cnt;
    do_req(3'd5);
    feed(0, 5, 5, 0);
    n_tests++;
    if (err_o !== 1'b1 || mem_rready_o !== 1'b1) begin
      n_fail++; $display("FAIL rlast_early err=%b rready=%b required=1,1", err_o, mem_rready_o);
    end
    feed(6, 7, 5, 0);
    tick();
    n_tests++;
    if (wr_cnt !== w0 + 1 || wr_data !== exp_entry(3'd5) || err_o !== 1'b1) begin
      n_fail++; $display("FAIL rlast_line writes=%0d required=1 err=%b required=1", wr_cnt - w0, err_o);
    end
  endtask

  task automatic test_reset_abort();
    int w0;
    rand_words(); w0 = wr_cnt;
    do_req($urandom);
    feed(0, 4, 9, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    err_exp = 1'b0;
    n_tests++;
    if (req_ready_o !== 1'b1 || err_o !== 1'b0 || fifo_wdata_o !== '0) begin
      n_fail++; $display("FAIL abort_state ready=%b err=%b wdata=%h required=1,0,0", req_ready_o, err_o, fifo_wdata_o);
    end
    feed(5, 7, 7, 0);
    tick();
    n_tests++;
    if (wr_cnt !== w0 || req_ready_o !== 1'b1 || mem_rready_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_ignored writes=%0d required=0 ready=%b", wr_cnt - w0, req_ready_o);
    end
    rand_words();
    do_req(3'd0);
    feed(0, 7, 7, 0);
    tick();
    n_tests++;
    if (wr_cnt !== w0 + 1 || wr_data !== exp_entry(3'd0) || err_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_clean data=%h required=%h err=%b", wr_data, exp_entry(3'd0), err_o);
    end
  endtask

  task automatic test_req_held();
    int w0;
    rand_words(); w0 = wr_cnt;
    req_valid_i = 1'b1; req_offset_i = 3'd6;
    tick();
    req_offset_i = 3'd1;
    feed(0, 7, 7, 20);
    n_tests++;
    if (req_ready_o !== 1'b0 || fifo_wren_o !== 1'b1 || fifo_wdata_o !== exp_entry(3'd6)) begin
      n_fail++; $display("FAIL held_push ready=%b wren=%b required=0,1", req_ready_o, fifo_wren_o);
    end
    tick();
    n_tests++;
    if (req_ready_o !== 1'b1 || wr_cnt !== w0 + 1) begin
      n_fail++; $display("FAIL held_idle ready=%b writes=%0d required=1,1", req_ready_o, wr_cnt - w0);
    end
    tick();
    req_valid_i = 1'b0;
    n_tests++;
    if (req_ready_o !== 1'b0 || mem_rready_o !== 1'b1) begin
      n_fail++; $display("FAIL held_second ready=%b rready=%b required=0,1", req_ready_o, mem_rready_o);
    end
    rand_words();
    feed(0, 7, 7, 0);
    tick();
    n_tests++;
    if (wr_cnt !== w0 + 2 || wr_data !== exp_entry(3'd1)) begin
      n_fail++; $display("FAIL held_count writes=%0d required=2 data=%h required=%h", wr_cnt - w0, wr_data, exp_entry(3'd1));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int w0, rl, fc;
      logic [2:0] ofs;
      ofs = $urandom; rand_words(); w0 = wr_cnt;
      rl = ($urandom_range(3) == 0) ? $urandom_range(8) : 7;
      fc = $urandom_range(3);
      do_req(ofs);
      feed(0, 7, rl, 30);
      fifo_full_i = (fc != 0);
      for (int c = 0; c < fc; c++) tick();
      fifo_full_i = 1'b0;
      tick();
      n_tests++;
      if (wr_cnt !== w0 + 1 || wr_data !== exp_entry(ofs) || err_o !== err_exp) begin
        n_fail++;
        $display("FAIL rand_line it=%0d writes=%0d required=1 data=%h required=%h err=%b required=%b",
                 it, wr_cnt - w0, wr_data, exp_entry(ofs), err_o, err_exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_offset_i = '0; mem_rdata_i = '0;
    mem_rlast_i = 1'b0; mem_rvalid_i = 1'b0; fifo_full_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_rlast_err();
    test_reset_abort();
    test_req_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
